// File: rtl/mips_pkg.sv
// Opcode constants, FSM state encoding and decoded-control types for the MIPS fetch/decode slice.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StIssue = 2'd1,
    StHalt  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    branch;
    logic    mem_read;
    logic    mem_to_reg;
    logic    mem_write;
    logic    alu_src;
    logic    reg_write;
    logic    jump;
    logic    illegal;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CtrlNone = ctrl_t'('0);

endpackage

// File: rtl/mips_decoder.sv
// Combinational opcode-to-control decoder; all controls are forced low when nothing is presented.
module mips_decoder
  import mips_pkg::*;
(
  input  logic       valid,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CtrlNone;
    if (valid) begin
      case (opcode)
        OpRtype: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = AluFunct;
        end
        OpLw: begin
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.reg_write  = 1'b1;
        end
        OpSw: begin
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
        end
        OpBeq, OpBne: begin
          ctrl.branch = 1'b1;
          ctrl.alu_op = AluSub;
        end
        OpAddiu: begin
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        OpJ: begin
          ctrl.jump = 1'b1;
        end
        OpJal: begin
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        default: begin
          ctrl.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mips_fetch_decode.sv
// Single-outstanding instruction fetch with in-place decode, optional branch delay slot and
// halt-on-jump-to-zero.
module mips_fetch_decode
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC00000),
  parameter int unsigned       DELAY_SLOT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] instr_address,
  output logic              instr_read,
  input  logic              instr_waitrequest,
  input  logic [31:0]       instr_readdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              dec_valid,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic              reg_dst,
  output logic              branch,
  output logic              mem_read,
  output logic              mem_to_reg,
  output logic              mem_write,
  output logic              alu_src,
  output logic              reg_write,
  output logic              jump,
  output logic              illegal,
  output logic [1:0]        alu_op,
  output logic              active
);

  localparam bit                UseDelaySlot = (DELAY_SLOT != 0);
  localparam logic [ADDR_W-1:0] PcStep       = ADDR_W'(4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] dec_pc_q, dec_pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  // Set when the delay slot of a jump-to-zero has been accepted; its issue ends in HALT.
  logic              halt_arm_q, halt_arm_d;
  ctrl_t             ctrl;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    dec_pc_d      = dec_pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    halt_arm_d    = halt_arm_q;

    unique case (state_q)
      StFetch: begin
        if (!instr_waitrequest) begin
          ir_d     = instr_readdata;
          dec_pc_d = pc_q;
          pc_d     = pc_q + PcStep;
          state_d  = StIssue;
          if (UseDelaySlot && pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
            halt_arm_d   = (pend_target_q == '0);
          end
        end
      end
      StIssue: begin
        if (!stall) begin
          state_d = halt_arm_q ? StHalt : StFetch;
        end
      end
      StHalt: begin
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // Redirect overrides the normal flow; without a delay slot it squashes this cycle's work.
    if (redirect_valid && (state_q != StHalt)) begin
      if (UseDelaySlot) begin
        pend_valid_d  = 1'b1;
        pend_target_d = redirect_target;
      end else begin
        pc_d    = redirect_target;
        state_d = (redirect_target == '0) ? StHalt : StFetch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFetch;
      pc_q          <= RESET_VECTOR;
      ir_q          <= '0;
      dec_pc_q      <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      halt_arm_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      dec_pc_q      <= dec_pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      halt_arm_q    <= halt_arm_d;
    end
  end

  assign instr_read    = ~reset & (state_q == StFetch);
  assign instr_address = pc_q;
  assign dec_valid     = ~reset & (state_q == StIssue);
  assign active        = reset | (state_q != StHalt);
  assign dec_pc        = dec_pc_q;
  assign rs            = ir_q[25:21];
  assign rt            = ir_q[20:16];
  assign rd            = ir_q[15:11];
  assign imm           = ir_q[15:0];

  mips_decoder u_decoder (
    .valid  (dec_valid),
    .opcode (ir_q[31:26]),
    .ctrl   (ctrl)
  );

  assign reg_dst    = ctrl.reg_dst;
  assign branch     = ctrl.branch;
  assign mem_read   = ctrl.mem_read;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign mem_write  = ctrl.mem_write;
  assign alu_src    = ctrl.alu_src;
  assign reg_write  = ctrl.reg_write;
  assign jump       = ctrl.jump;
  assign illegal    = ctrl.illegal;
  assign alu_op     = ctrl.alu_op;

endmodule

// File: tb/tb_mips_fetch_decode.sv
// Scoreboard bench: a delay-slot instance under directed and random traffic, plus a
// no-delay-slot instance for immediate redirect and halt behaviour.
module tb_mips_fetch_decode;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: delay slot enabled
  logic        reset, instr_waitrequest, stall, redirect_valid;
  logic [31:0] instr_readdata, redirect_target, instr_address, dec_pc;
  logic        instr_read, dec_valid, active;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jump, illegal;
  logic [1:0]  alu_op;
  logic [10:0] ctrl_vec;
  assign ctrl_vec = {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jump,
                     illegal, alu_op};

  mips_fetch_decode #(.ADDR_W(32), .RESET_VECTOR(RV), .DELAY_SLOT(1)) u_dut (
    .clk(clk), .reset(reset), .instr_address(instr_address), .instr_read(instr_read),
    .instr_waitrequest(instr_waitrequest), .instr_readdata(instr_readdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .dec_valid(dec_valid),
    .dec_pc(dec_pc), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .reg_dst(reg_dst), .branch(branch),
    .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
    .reg_write(reg_write), .jump(jump), .illegal(illegal), .alu_op(alu_op), .active(active)
  );

  // Instance B: no delay slot
  logic        b_reset, b_instr_waitrequest, b_stall, b_redirect_valid;
  logic [31:0] b_instr_readdata, b_redirect_target, b_instr_address, b_dec_pc;
  logic        b_instr_read, b_dec_valid, b_active;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [15:0] b_imm;
  logic        b_reg_dst, b_branch, b_mem_read, b_mem_to_reg, b_mem_write, b_alu_src;
  logic        b_reg_write, b_jump, b_illegal;
  logic [1:0]  b_alu_op;

  mips_fetch_decode #(.ADDR_W(32), .RESET_VECTOR(RV), .DELAY_SLOT(0)) u_dut_nods (
    .clk(clk), .reset(b_reset), .instr_address(b_instr_address), .instr_read(b_instr_read),
    .instr_waitrequest(b_instr_waitrequest), .instr_readdata(b_instr_readdata),
    .stall(b_stall), .redirect_valid(b_redirect_valid), .redirect_target(b_redirect_target),
    .dec_valid(b_dec_valid), .dec_pc(b_dec_pc), .rs(b_rs), .rt(b_rt), .rd(b_rd), .imm(b_imm),
    .reg_dst(b_reg_dst), .branch(b_branch), .mem_read(b_mem_read), .mem_to_reg(b_mem_to_reg),
    .mem_write(b_mem_write), .alu_src(b_alu_src), .reg_write(b_reg_write), .jump(b_jump),
    .illegal(b_illegal), .alu_op(b_alu_op), .active(b_active)
  );

  // Reference decode table: {reg_dst,branch,mem_read,mem_to_reg,mem_write,alu_src,
  // reg_write,jump,illegal,alu_op[1:0]}
  function automatic logic [10:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00:        return 11'b1_0_0_0_0_0_1_0_0_10;
      6'h23:        return 11'b0_0_1_1_0_1_1_0_0_00;
      6'h2B:        return 11'b0_0_0_0_1_1_0_0_0_00;
      6'h04, 6'h05: return 11'b0_1_0_0_0_0_0_0_0_01;
      6'h09:        return 11'b0_0_0_0_0_1_1_0_0_00;
      6'h02:        return 11'b0_0_0_0_0_0_0_1_0_00;
      6'h03:        return 11'b0_0_0_0_0_0_1_1_0_00;
      default:      return 11'b0_0_0_0_0_0_0_0_1_00;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h09, 6'h02, 6'h03, 6'h3F,
                             6'h11};
    logic [5:0] op;
    op = ($urandom_range(3) == 0) ? 6'($urandom) : ops[$urandom_range(9)];
    return {op, 26'($urandom)};
  endfunction

  // Reference model: program order of fetch addresses with a one-instruction delay slot.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;

  always @(negedge clk) begin
    if (reset) begin
      m_pc   = RV;
      m_pend = 1'b0;
      m_tgt  = '0;
      exp_q.delete();
    end else begin
      if (instr_read && !instr_waitrequest) begin
        exp_q.push_back('{pc: m_pc, ir: instr_readdata});
        if (m_pend) begin
          m_pc   = m_tgt;
          m_pend = 1'b0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
      if (redirect_valid && dec_valid) begin
        m_pend = 1'b1;
        m_tgt  = redirect_target;
      end
    end
  end

  // Monitor: each new presentation pops one expectation; held presentations must not change.
  exp_t cur;
  logic prev_dv = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_dv = 1'b0;
    end else begin
      if (dec_valid) begin
        if (!prev_dv) begin
          check("sb_expect_available", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
          else cur = '0;
        end
        check("sb_dec_pc", dec_pc, cur.pc);
        check("sb_fields", {rs, rt, rd, imm}, {cur.ir[25:21], cur.ir[20:16], cur.ir[15:11],
                                               cur.ir[15:0]});
        check("sb_ctrl", ctrl_vec, ref_ctrl(cur.ir[31:26]));
      end else begin
        check("idle_ctrl_zero", ctrl_vec, 11'd0);
      end
      prev_dv = dec_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    logic        prev;
    logic [31:0] t;

    reset = 1'b1; instr_waitrequest = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    instr_readdata = '0; redirect_target = '0;
    b_reset = 1'b1; b_instr_waitrequest = 1'b1; b_stall = 1'b0; b_redirect_valid = 1'b0;
    b_instr_readdata = '0; b_redirect_target = '0;
    repeat (3) tick();

    // No-delay-slot instance: immediate redirect, squash, halt on target 0
    b_reset = 1'b0; b_instr_waitrequest = 1'b0; b_instr_readdata = 32'h24090005;
    #1;
    check("b_first_req", b_instr_read, 1'b1);
    check("b_first_addr", b_instr_address, RV);
    tick();
    check("b_issue_valid", b_dec_valid, 1'b1);
    check("b_issue_pc", b_dec_pc, RV);
    b_stall = 1'b1; b_redirect_valid = 1'b1; b_redirect_target = 32'h400;
    tick();
    check("b_redir_squash", b_dec_valid, 1'b0);
    check("b_redir_addr", b_instr_address, 32'h400);
    b_redirect_target = 32'h800;
    tick();
    check("b_accept_squash", b_dec_valid, 1'b0);
    check("b_accept_redir_addr", b_instr_address, 32'h800);
    b_redirect_target = 32'h0;
    tick();
    check("b_halt_active", b_active, 1'b0);
    check("b_halt_read", b_instr_read, 1'b0);
    check("b_halt_dv", b_dec_valid, 1'b0);
    b_redirect_target = 32'hC00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_halt_ignores_redirect", {b_active, b_instr_read}, 2'b00);
    end
    b_redirect_valid = 1'b0; b_reset = 1'b1;
    tick();
    check("b_reset_active", b_active, 1'b1);
    check("b_reset_read", b_instr_read, 1'b0);
    b_reset = 1'b0;
    #1;
    check("b_restart_read", b_instr_read, 1'b1);
    check("b_restart_addr", b_instr_address, RV);
    b_instr_waitrequest = 1'b1;

    // Delay-slot instance: reset state
    check("rst_read", instr_read, 1'b0);
    check("rst_dv", dec_valid, 1'b0);
    check("rst_active", active, 1'b1);
    check("rst_addr", instr_address, RV);
    check("rst_dec_pc", dec_pc, 32'h0);

    // ADDIU $9, $0, 5 with zero wait
    reset = 1'b0; instr_waitrequest = 1'b0; instr_readdata = 32'h24090005;
    #1;
    check("first_read", instr_read, 1'b1);
    check("first_addr", instr_address, RV);
    tick();
    check("addiu_dv", dec_valid, 1'b1);
    check("addiu_alu_src", alu_src, 1'b1);
    check("addiu_reg_write", reg_write, 1'b1);
    check("addiu_rt", rt, 5'd9);
    check("addiu_imm", imm, 16'h0005);
    tick();

    // Three wait cycles: address held for four cycles, one presentation
    instr_waitrequest = 1'b1; instr_readdata = 32'h00851020;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) instr_waitrequest = 1'b0;
      check("wait_addr_stable", instr_address, RV + 32'd4);
      check("wait_read_held", instr_read, 1'b1);
      tick();
    end
    instr_waitrequest = 1'b1;
    pulses = 0; prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dec_valid && !prev) pulses++;
      prev = dec_valid;
      tick();
    end
    check("wait_one_pulse", pulses, 1);

    // LW stalled five cycles with two redirects; stall during FETCH is ignored
    stall = 1'b1; instr_readdata = 32'h8C430004; instr_waitrequest = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_dv", dec_valid, 1'b1);
      check("stall_dec_pc", dec_pc, RV + 32'd8);
      check("stall_mem_read", mem_read, 1'b1);
      redirect_valid  = (i == 2) || (i == 4);
      redirect_target = (i == 2) ? 32'h2000 : 32'h1000;
      tick();
    end
    stall = 1'b0; redirect_valid = 1'b0;
    check("stall_release_dv", dec_valid, 1'b1);
    tick();
    check("delay_slot_addr", instr_address, RV + 32'd12);
    instr_readdata = 32'hAC220010;
    tick();
    tick();
    check("redirect_newest_addr", instr_address, 32'h1000);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      instr_waitrequest = ($urandom_range(9) < 3);
      stall             = ($urandom_range(9) < 3);
      instr_readdata    = rand_instr();
      redirect_valid    = dec_valid && ($urandom_range(7) == 0);
      t = $urandom & 32'hFFFF_FFFC;
      redirect_target   = (t == 0) ? 32'h4 : t;
      tick();
    end

    // Jump to 0 after a delay slot halts; redirect afterwards is ignored
    instr_waitrequest = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    instr_readdata = 32'h00000020;
    for (int i = 0; i < 20 && !dec_valid; i++) tick();
    check("halt_setup_dv", dec_valid, 1'b1);
    redirect_valid = 1'b1; redirect_target = 32'h0;
    tick();
    redirect_valid = 1'b0;
    check("halt_delay_slot_read", instr_read, 1'b1);
    repeat (6) tick();
    check("halt_active", active, 1'b0);
    check("halt_read", instr_read, 1'b0);
    check("halt_dv", dec_valid, 1'b0);
    redirect_valid = 1'b1; redirect_target = 32'h3000;
    repeat (2) tick();
    redirect_valid = 1'b0;
    check("halt_ignores_redirect", {active, instr_read}, 2'b00);

    // Illegal opcode, then reset during a stalled ISSUE
    reset = 1'b1;
    tick();
    reset = 1'b0; instr_readdata = 32'hFC1234AB; instr_waitrequest = 1'b0;
    tick();
    check("illegal_ctrl", ctrl_vec, 11'b0_0_0_0_0_0_0_0_1_00);
    stall = 1'b1;
    tick();
    check("stalled_issue_dv", dec_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("reset_in_issue_dv", dec_valid, 1'b0);
    tick();
    reset = 1'b0; stall = 1'b0;
    #1;
    check("post_reset_read", instr_read, 1'b1);
    check("post_reset_addr", instr_address, RV);
    repeat (4) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
